// File: rtl/irq_dispatch.sv
// irq_dispatch: captures peripheral interrupts, redirects fetch to the ISR and back on mret; define IRQ_LEVEL_EN for level-sensitive sources
module irq_dispatch #(
   parameter int N_SRC  = 5,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_SRC-1:0]  irq_raw,
   input  logic [N_SRC-1:0]  irq_mask,
   output logic [N_SRC-1:0]  irq_sources,
   input  logic [ADDR_W-1:0] irq_target,
   input  logic              instr_boundary,
   input  logic [ADDR_W-1:0] pc_next,
   input  logic              mret,
   output logic              redirect_valid,
   input  logic              redirect_ready,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              irq_active,
   output logic [2:0]        irq_cause,
   output logic [ADDR_W-1:0] epc
);
   typedef enum logic [1:0] {IDLE, TAKE, ACTIVE, RET} state_t;
   state_t state, state_n;
   logic [N_SRC-1:0] pending, pending_n, prev_raw, win_oh;
   logic [2:0] win, irq_cause_n;
   logic take, redirect_valid_n, irq_active_n;
   logic [ADDR_W-1:0] redirect_pc_n, epc_n;
   // highest-index pending source wins, matching the controller's target selection
   always_comb begin
      win = '0;
      for (int i = 0; i < N_SRC; i++) if (pending[i]) win = 3'(i);
   end
   assign win_oh = N_SRC'(1) << win;
   assign take = (state == IDLE) && (|pending) && instr_boundary;
   assign irq_sources = ~pending;
`ifdef IRQ_LEVEL_EN
   assign pending_n = ~irq_raw & irq_mask;
`else
   assign pending_n = ((pending & ~(take ? win_oh : '0)) | (~irq_raw & prev_raw)) & irq_mask;
`endif
   // next-state and redirect bookkeeping
   always_comb begin
      state_n = state;
      redirect_valid_n = redirect_valid;
      redirect_pc_n = redirect_pc;
      irq_active_n = irq_active;
      irq_cause_n = irq_cause;
      epc_n = epc;
      case (state)
         IDLE: if (take) begin
            state_n = TAKE;
            epc_n = pc_next;
            redirect_pc_n = irq_target;
            irq_cause_n = win;
            redirect_valid_n = 1'b1;
            irq_active_n = 1'b1;
         end
         TAKE: if (redirect_ready) begin
            state_n = ACTIVE;
            redirect_valid_n = 1'b0;
         end
         ACTIVE: if (mret) begin
            state_n = RET;
            redirect_pc_n = epc;
            redirect_valid_n = 1'b1;
         end
         RET: if (redirect_ready) begin
            state_n = IDLE;
            redirect_valid_n = 1'b0;
            irq_active_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end
   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pending <= '0;
         prev_raw <= '1;
         redirect_valid <= 1'b0;
         redirect_pc <= '0;
         irq_active <= 1'b0;
         irq_cause <= '0;
         epc <= '0;
      end else begin
         state <= state_n;
         pending <= pending_n;
         prev_raw <= irq_raw;
         redirect_valid <= redirect_valid_n;
         redirect_pc <= redirect_pc_n;
         irq_active <= irq_active_n;
         irq_cause <= irq_cause_n;
         epc <= epc_n;
      end
   end
endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: directed checks of edge capture, priority, masking, backpressure, return and reset
module tb_irq_dispatch;
   logic clk = 0, reset = 1;
   logic [4:0] irq_raw = 5'h1F, irq_mask = 0, irq_sources;
   logic [31:0] irq_target = 0, pc_next = 0, redirect_pc, epc;
   logic instr_boundary = 0, mret = 0, redirect_ready = 1, redirect_valid, irq_active;
   logic [2:0] irq_cause;
   int checks = 0, errors = 0;

   irq_dispatch dut (
      .clk(clk), .reset(reset), .irq_raw(irq_raw), .irq_mask(irq_mask),
      .irq_sources(irq_sources), .irq_target(irq_target),
      .instr_boundary(instr_boundary), .pc_next(pc_next), .mret(mret),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .irq_active(irq_active),
      .irq_cause(irq_cause), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_src"}, 32'(irq_sources), 32'h1F);
      check({tag, "_rv"}, 32'(redirect_valid), 0);
      check({tag, "_rpc"}, redirect_pc, 0);
      check({tag, "_act"}, 32'(irq_active), 0);
      check({tag, "_cause"}, 32'(irq_cause), 0);
      check({tag, "_epc"}, epc, 0);
   endtask

   initial begin
      tick; tick;
      reset = 0;
      check_reset_state("rst");

      // edge latching on ext1
      irq_mask = 5'h01; irq_target = 32'h100; pc_next = 32'h40; instr_boundary = 1;
      irq_raw = 5'h1E; tick;
      check("e_src_pend", 32'(irq_sources), 32'h1E);
      check("e_rv_pre", 32'(redirect_valid), 0);
      irq_raw = 5'h1F; tick;
      check("e_rv", 32'(redirect_valid), 1);
      check("e_rpc", redirect_pc, 32'h100);
      check("e_epc", epc, 32'h40);
      check("e_cause", 32'(irq_cause), 0);
      check("e_act", 32'(irq_active), 1);
      check("e_src_clr", 32'(irq_sources), 32'h1F);
      tick;
      check("e_rv_pulse", 32'(redirect_valid), 0);
      check("e_act_isr", 32'(irq_active), 1);

      // return
      mret = 1; tick; mret = 0;
      check("r_rv", 32'(redirect_valid), 1);
      check("r_rpc", redirect_pc, 32'h40);
      tick;
      check("r_rv_done", 32'(redirect_valid), 0);
      check("r_act", 32'(irq_active), 0);
      mret = 1; tick; mret = 0;
      check("r_idle_mret_rv", 32'(redirect_valid), 0);
      tick;
      check("r_idle_mret_rv2", 32'(redirect_valid), 0);
      check("r_idle_mret_act", 32'(irq_active), 0);

      // priority: ext2 and tim2 together
      irq_mask = 5'h1F; irq_target = 32'h300; pc_next = 32'h80;
      irq_raw = 5'h15; tick;
      check("p_src_both", 32'(irq_sources), 32'h15);
      irq_raw = 5'h1F; tick;
      check("p_cause1", 32'(irq_cause), 3);
      check("p_rpc1", redirect_pc, 32'h300);
      check("p_src_left", 32'(irq_sources), 32'h1D);
      irq_target = 32'h200; tick;
      mret = 1; tick; mret = 0;
      tick;
      check("p_idle_gap_act", 32'(irq_active), 0);
      check("p_idle_gap_rv", 32'(redirect_valid), 0);
      tick;
      check("p_cause2", 32'(irq_cause), 1);
      check("p_rpc2", redirect_pc, 32'h200);
      check("p_rv2", 32'(redirect_valid), 1);
      check("p_src_empty", 32'(irq_sources), 32'h1F);
      tick;
      mret = 1; tick; mret = 0;
      tick;
      check("p_done_act", 32'(irq_active), 0);

      // masked edge discarded
      irq_mask = 0;
      irq_raw = 5'h1B; tick;
      irq_raw = 5'h1F; tick;
      irq_mask = 5'h04; tick; tick;
      check("m_src", 32'(irq_sources), 32'h1F);
      check("m_rv", 32'(redirect_valid), 0);
      check("m_act", 32'(irq_active), 0);

      // backpressure in TAKE
      redirect_ready = 0; irq_target = 32'h500; pc_next = 32'h60;
      irq_raw = 5'h1B; tick;
      irq_raw = 5'h1F; tick;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("b_rv%0d", i), 32'(redirect_valid), 1);
         check($sformatf("b_rpc%0d", i), redirect_pc, 32'h500);
         if (i < 3) tick;
      end
      redirect_ready = 1; tick;
      check("b_active_rv", 32'(redirect_valid), 0);
      check("b_active_act", 32'(irq_active), 1);
      check("b_cause", 32'(irq_cause), 2);
      check("b_epc", epc, 32'h60);
      mret = 1; tick; mret = 0;
      check("b_ret_rpc", redirect_pc, 32'h60);
      tick;
      check("b_ret_act", 32'(irq_active), 0);

      // reset while in TAKE with another source still pending
      redirect_ready = 0; irq_mask = 5'h05;
      irq_raw = 5'h1A; tick;
      irq_raw = 5'h1F; tick;
      check("x_rv", 32'(redirect_valid), 1);
      check("x_src", 32'(irq_sources), 32'h1E);
      reset = 1; tick; reset = 0;
      check_reset_state("x_rst");
      redirect_ready = 1; tick; tick;
      check("x_after_rv", 32'(redirect_valid), 0);
      check("x_after_src", 32'(irq_sources), 32'h1F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
